// File: rtl/xoroshiro128p_rewind.sv
// xoroshiro128p_rewind: steps a xoroshiro128+ state backwards N times and reports the earlier state and its output word
module xoroshiro128p_rewind #(
  parameter int STEP_W = 16,
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [127:0]      state_in,
  input  logic [STEP_W-1:0] steps_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [127:0]      state_out,
  output logic [63:0]       out_word
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [127:0] r_work, r_state_out, w_g1, w_g2, w_step, w_final;
  logic [STEP_W-1:0] r_rem;
  logic w_fin;
  function automatic logic [127:0] inv(input logic [127:0] s);
    logic [63:0] x, t, s0;
    x  = (s[127:64] >> 36) | (s[127:64] << 28);
    t  = s[63:0] ^ x ^ (x << 14);
    s0 = (t >> 55) | (t << 9);
    return {x ^ s0, s0};
  endfunction
  assign w_g1    = inv(r_work);
  assign w_g2    = inv(w_g1);
  assign w_step  = (UNROLL == 2) ? w_g2 : w_g1;
  assign w_fin   = r_rem <= STEP_W'(UNROLL);
  assign w_final = (r_rem == '0) ? r_work : (r_rem == STEP_W'(1)) ? w_g1 : w_g2;
  // next state: abort beats completion so an aborted request never pulses done
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = start ? RUN : IDLE;
    else if (abort) w_next = IDLE;
    else if (r_state == RUN) w_next = w_fin ? DONE : RUN;
    else w_next = IDLE;
  end
  // state, working registers and the held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_rem       <= '0;
      r_state_out <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_work <= state_in;
        r_rem  <= steps_in;
      end else if (r_state == RUN && !w_fin) begin
        r_work <= w_step;
        r_rem  <= r_rem - STEP_W'(UNROLL);
      end
      if (r_state == RUN && w_fin && !abort) r_state_out <= w_final;
    end
  end
  assign ready     = r_state == IDLE;
  assign busy      = r_state == RUN;
  assign done      = (r_state == DONE) && !abort;
  assign state_out = r_state_out;
  assign out_word  = r_state_out[63:0] + r_state_out[127:64];
endmodule
